// File: rtl/scan_sequencer_16_pkg.sv
// Shared constants and state encoding for the channel-scan sequencer.
package scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_sequencer_16_next_chan_finder.sv
// Combinational search for the lowest enabled channel, either from channel 0
// or strictly above the current channel (no wrap-around within a pass).
module next_chan_finder
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              from_start_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              found_o
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    nxt_o   = {SEL_W{1'b0}};
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (i > int'(cur_i)))) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end else begin
        nxt_o   = nxt_o;
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer_16.sv
// Channel-scan sequencer: steps a 4-bit select through the enabled channels of
// a latched mask, holding each for dwell+1 cycles, in one-shot or continuous mode.
module scan_sequencer_16
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               continuous_i,
  input  logic [NUM_CH-1:0]  chan_mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               sel_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wrap_o
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;

  logic [SEL_W-1:0]   above_nxt_s, first_nxt_s;
  logic               above_found_s, first_found_s;
  logic               expire_s;

  // Next channel above the current one within the latched mask.
  next_chan_finder u_above (
    .mask_i       (mask_q),
    .cur_i        (sel_q),
    .from_start_i (1'b0),
    .nxt_o        (above_nxt_s),
    .found_o      (above_found_s)
  );

  // First channel of the live mask, used at start and at each pass restart.
  next_chan_finder u_first (
    .mask_i       (chan_mask_i),
    .cur_i        ({SEL_W{1'b0}}),
    .from_start_i (1'b1),
    .nxt_o        (first_nxt_s),
    .found_o      (first_found_s)
  );

  assign expire_s = (cnt_q == dwell_q);

  // Next-state, counter and latch logic; outputs derive from the next state.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (start_i && first_found_s && !stop_i) begin
          mask_d  = chan_mask_i;
          dwell_d = dwell_i;
          sel_d   = first_nxt_s;
          cnt_d   = {DWELL_W{1'b0}};
          state_d = DWELL;
        end else if (start_i && !first_found_s) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DWELL: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (!expire_s) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else if (above_found_s) begin
          sel_d = above_nxt_s;
          cnt_d = {DWELL_W{1'b0}};
        end else if (!continuous_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (first_found_s) begin
          // Pass restart: the live mask and dwell take effect only here.
          mask_d  = chan_mask_i;
          dwell_d = dwell_i;
          sel_d   = first_nxt_s;
          cnt_d   = {DWELL_W{1'b0}};
          wrap_d  = 1'b1;
        end else begin
          mask_d  = chan_mask_i;
          dwell_d = dwell_i;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sel_valid_d = (state_d == DWELL);
    busy_d      = (state_d == DWELL);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= {SEL_W{1'b0}};
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= {DWELL_W{1'b0}};
      dwell_q     <= {DWELL_W{1'b0}};
      mask_q      <= {NUM_CH{1'b0}};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      mask_q      <= mask_d;
    end
  end

  assign sel_o       = sel_q;
  assign sel_valid_o = sel_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_scan_sequencer_16.sv
// Self-checking bench for scan_sequencer_16: directed vector table, hand-written
// corner sequences and randomized scans against a pass-level trace model.
module tb_scan_sequencer_16;
  import scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i, continuous_i;
  logic [15:0] chan_mask_i;
  logic [7:0]  dwell_i;
  logic [3:0]  sel_o;
  logic        sel_valid_o, busy_o, done_o, wrap_o;

  scan_sequencer_16 #(.DWELL_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .continuous_i (continuous_i),
    .chan_mask_i  (chan_mask_i),
    .dwell_i      (dwell_i),
    .sel_o        (sel_o),
    .sel_valid_o  (sel_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wrap_o       (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wrap;
  } obs_t;

  typedef struct {
    logic        start;
    logic        stop;
    logic        cont;
    logic [15:0] mask;
    logic [7:0]  dwell;
    obs_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic obs_t mk_obs(input int s, input logic v, input logic b,
                                  input logic d, input logic w);
    obs_t o;
    o.sel = 4'(s); o.valid = v; o.busy = b; o.done = d; o.wrap = w;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic s, input logic p, input logic c,
                                  input logic [15:0] m, input logic [7:0] d, input obs_t e);
    vec_t r;
    r.start = s; r.stop = p; r.cont = c; r.mask = m; r.dwell = d; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = {sel_o, sel_valid_o, busy_o, done_o, wrap_o};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d valid=%b busy=%b done=%b wrap=%b, expected sel=%0d valid=%b busy=%b done=%b wrap=%b",
               name, got.sel, got.valid, got.busy, got.done, got.wrap,
               exp.sel, exp.valid, exp.busy, exp.done, exp.wrap);
    end
  endtask

  // Builds the whole expected output trace of an npass scan from the rules
  // (ascending enabled channels, dwell+1 cycles each, wrap on pass restart,
  // done after the last pass), then drives the scan with noise on inputs that
  // must be ignored mid-pass.
  task automatic run_trace(input logic [15:0] m, input logic [7:0] d,
                           input int npass, input string name);
    obs_t exp_q[$];
    int   pc, last, plen, t;
    logic first;
    pc = 0; last = 0;
    for (int ch = 0; ch < 16; ch++) begin
      if (m[ch]) begin pc++; last = ch; end
    end
    plen = pc * (int'(d) + 1);
    for (int p = 0; p < npass; p++) begin
      first = 1'b1;
      for (int ch = 0; ch < 16; ch++) begin
        if (m[ch]) begin
          for (int k = 0; k <= int'(d); k++) begin
            exp_q.push_back(mk_obs(ch, 1'b1, 1'b1, 1'b0, first && (p > 0)));
            first = 1'b0;
          end
        end
      end
    end
    exp_q.push_back(mk_obs(last, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk_obs(last, 1'b0, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    start_i = 1'b1; stop_i = 1'b0; chan_mask_i = m; dwell_i = d;
    continuous_i = 1'($urandom);
    for (int idx = 0; idx < exp_q.size(); idx++) begin
      @(negedge clk);
      check(name, exp_q[idx]);
      t = idx + 1;
      if (t <= npass * plen) begin
        start_i = 1'($urandom);
        if (t % plen == 0) begin
          chan_mask_i  = m;
          dwell_i      = d;
          continuous_i = (t < npass * plen);
        end else begin
          chan_mask_i  = 16'($urandom);
          dwell_i      = 8'($urandom);
          continuous_i = 1'($urandom);
        end
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rm;
    // Continuous 0003/dwell1 with a mid-pass change to 0004/dwell0 that only
    // lands at the following wrap; then empty-mask start and start+stop.
    vecs[0]  = mk_vec(1'b1, 1'b0, 1'b1, 16'h0003, 8'd1, mk_obs(0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[1]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0003, 8'd1, mk_obs(0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[2]  = mk_vec(1'b1, 1'b0, 1'b1, 16'h0003, 8'd1, mk_obs(1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[3]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0003, 8'd1, mk_obs(1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[4]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0003, 8'd1, mk_obs(0, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[5]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0004, 8'd0, mk_obs(0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[6]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0004, 8'd0, mk_obs(1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[7]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0004, 8'd0, mk_obs(1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[8]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0004, 8'd0, mk_obs(2, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[9]  = mk_vec(1'b0, 1'b0, 1'b1, 16'h0004, 8'd0, mk_obs(2, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[10] = mk_vec(1'b0, 1'b0, 1'b0, 16'h0004, 8'd0, mk_obs(2, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs[11] = mk_vec(1'b0, 1'b0, 1'b0, 16'h0004, 8'd0, mk_obs(2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs[12] = mk_vec(1'b1, 1'b0, 1'b0, 16'h0000, 8'd3, mk_obs(2, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs[13] = mk_vec(1'b0, 1'b0, 1'b0, 16'h0000, 8'd3, mk_obs(2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs[14] = mk_vec(1'b1, 1'b1, 1'b0, 16'h0010, 8'd0, mk_obs(2, 1'b0, 1'b0, 1'b0, 1'b0));

    rst_n = 1'b0; start_i = 1'b1; stop_i = 1'b0; continuous_i = 1'b0;
    chan_mask_i = 16'hFFFF; dwell_i = 8'd0;
    #1;
    check("reset_state", mk_obs(0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    check("reset_held", mk_obs(0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_exit", mk_obs(0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 15; i++) begin
      start_i = vecs[i].start; stop_i = vecs[i].stop; continuous_i = vecs[i].cont;
      chan_mask_i = vecs[i].mask; dwell_i = vecs[i].dwell;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    start_i = 1'b0; stop_i = 1'b0;

    run_trace(16'hFFFF, 8'd0, 1, "all_dwell0");
    run_trace(16'h8421, 8'd2, 1, "m8421_dwell2");
    run_trace(16'h0001, 8'd0, 3, "min_pass_cont");

    // Stop on the same edge as channel 15's expiry: no done.
    @(negedge clk);
    start_i = 1'b1; chan_mask_i = 16'h8000; dwell_i = 8'd1; continuous_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    check("stop15_c1", mk_obs(15, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("stop15_c2", mk_obs(15, 1'b1, 1'b1, 1'b0, 1'b0));
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("stop15_idle", mk_obs(15, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("stop15_nodone", mk_obs(15, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset mid-scan at sel 7, then restart.
    start_i = 1'b1; chan_mask_i = 16'hFFFF; dwell_i = 8'd0; continuous_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_sel7", mk_obs(7, 1'b1, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check("reset_mid_scan", mk_obs(0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_exit", mk_obs(0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_i = 1'b1; chan_mask_i = 16'h00F0; dwell_i = 8'd1;
    @(negedge clk);
    start_i = 1'b0;
    check("restart_lowest", mk_obs(4, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("restart_hold", mk_obs(4, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("restart_next", mk_obs(5, 1'b1, 1'b1, 1'b0, 1'b0));
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;

    for (int r = 0; r < 24; r++) begin
      rm = 16'($urandom) & 16'($urandom);
      if (rm == 16'h0000) rm = 16'h0001 << $urandom_range(15, 0);
      run_trace(rm, 8'($urandom_range(3, 0)), $urandom_range(3, 1),
                $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
